// File: rtl/tdc_seq_pkg.sv
// Shared definitions for the TDC sequencer: state encoding, fixed command-ROM
// map and the transaction-boundary rule.
package tdc_seq_pkg;

  localparam int ADDR_W = 6;
  localparam int RES_W  = 24;

  localparam logic [ADDR_W-1:0] CFG_LAST    = 6'd17;
  localparam logic [ADDR_W-1:0] TRIG_ADDR   = 6'd18;
  localparam logic [ADDR_W-1:0] TRIG_LAST   = 6'd19;
  localparam logic [ADDR_W-1:0] TIME1_ADDR  = 6'd20;
  localparam logic [ADDR_W-1:0] CALIB1_ADDR = 6'd24;
  localparam logic [ADDR_W-1:0] CALIB2_ADDR = 6'd28;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = 6'd31;

  typedef enum logic [2:0] {
    ST_CFG,
    ST_FETCH,
    ST_LOAD,
    ST_XFER,
    ST_GAP,
    ST_READY,
    ST_WAIT_INT,
    ST_DONE
  } state_t;

  // Writes are 2-byte pairs; reads are 4-byte groups aligned on the ROM index.
  function automatic logic is_txn_end(input logic [ADDR_W-1:0] addr);
    return (addr < TIME1_ADDR) ? addr[0] : (addr[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/tdc_seq_ctrl_sync2.sv
// Two-flop synchronizer for the active-low TDC interrupt; idles high out of reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/tdc_seq_ctrl.sv
// Sequencer between the TDC command ROM and a byte-level SPI master: configures
// the TDC after reset, then runs trigger / wait-for-interrupt / readback on start.
module tdc_seq_ctrl
  import tdc_seq_pkg::*;
#(
  parameter int INT_TIMEOUT = 50000,
  parameter int CS_GAP      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              spi_start,
  output logic [7:0]        spi_tx,
  input  logic              spi_done,
  input  logic [7:0]        spi_rx,
  output logic              tdc_csn,
  input  logic              tdc_intb,
  output logic              cfg_done,
  output logic              busy,
  output logic              meas_valid,
  output logic              timeout,
  output logic [RES_W-1:0]  time1,
  output logic [RES_W-1:0]  calib1,
  output logic [RES_W-1:0]  calib2
);

  localparam int TO_W  = $clog2(INT_TIMEOUT + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(INT_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic                r_spi_start;
  logic [7:0]          r_spi_tx;
  logic                r_csn;
  logic                r_cfg_done;
  logic                r_busy;
  logic                r_meas_valid;
  logic                r_timeout;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [TO_W-1:0]     r_to_cnt;

  logic                w_intb_sync;
  logic                w_gap_last;
  logic                w_cap;
  logic                w_commit;
  logic [1:0]          w_lane;
  logic [2:0][RES_W-1:0] w_result;

  sync2 u_sync_intb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (tdc_intb),
    .o_q   (w_intb_sync)
  );

  assign w_gap_last = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);
  assign w_commit   = w_gap_last && (r_rom_addr == LAST_ADDR);
  assign w_lane     = (r_rom_addr < CALIB1_ADDR) ? 2'd0 :
                      (r_rom_addr < CALIB2_ADDR) ? 2'd1 : 2'd2;
  // Byte 0 of each read group is the command echo and is never captured.
  assign w_cap      = (r_state == ST_XFER) && spi_done &&
                      (r_rom_addr >= TIME1_ADDR) && (r_rom_addr[1:0] != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_CFG;
      r_rom_addr   <= '0;
      r_spi_start  <= 1'b0;
      r_spi_tx     <= '0;
      r_csn        <= 1'b1;
      r_cfg_done   <= 1'b0;
      r_busy       <= 1'b0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_gap_cnt    <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_spi_start  <= 1'b0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        ST_CFG: begin
          r_rom_addr <= '0;
          r_csn      <= 1'b0;
          r_busy     <= 1'b1;
          r_state    <= ST_FETCH;
        end
        ST_FETCH: begin
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_spi_tx    <= rom_data;
          r_spi_start <= 1'b1;
          r_state     <= ST_XFER;
        end
        ST_XFER: begin
          if (spi_done) begin
            if (is_txn_end(r_rom_addr)) begin
              r_csn     <= 1'b1;
              r_gap_cnt <= '0;
              r_state   <= ST_GAP;
            end else begin
              r_rom_addr <= r_rom_addr + 6'd1;
              r_state    <= ST_FETCH;
            end
          end
        end
        ST_GAP: begin
          if (w_gap_last) begin
            // The address of the finished transaction decides which phase follows.
            if (r_rom_addr == CFG_LAST) begin
              r_cfg_done <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= ST_READY;
            end else if (r_rom_addr == TRIG_LAST) begin
              r_to_cnt <= '0;
              r_state  <= ST_WAIT_INT;
            end else if (r_rom_addr == LAST_ADDR) begin
              r_meas_valid <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_rom_addr <= r_rom_addr + 6'd1;
              r_csn      <= 1'b0;
              r_state    <= ST_FETCH;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        ST_READY: begin
          if (start) begin
            r_rom_addr <= TRIG_ADDR;
            r_csn      <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_WAIT_INT: begin
          if (!w_intb_sync) begin
            r_rom_addr <= TIME1_ADDR;
            r_csn      <= 1'b0;
            r_state    <= ST_FETCH;
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_READY;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_READY;
        end
        default: begin
          r_state <= ST_CFG;
        end
      endcase
    end
  end

  // One shadow/result lane per read: 0 = TIME1, 1 = CALIB1, 2 = CALIB2.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [RES_W-1:0] r_shadow;
      logic [RES_W-1:0] r_result;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_shadow <= '0;
          r_result <= '0;
        end else begin
          if (w_cap && (w_lane == 2'(gi))) begin
            case (r_rom_addr[1:0])
              2'd1:    r_shadow[23:16] <= spi_rx;
              2'd2:    r_shadow[15:8]  <= spi_rx;
              2'd3:    r_shadow[7:0]   <= spi_rx;
              default: r_shadow        <= r_shadow;
            endcase
          end
          if (w_commit) begin
            r_result <= r_shadow;
          end
        end
      end

      assign w_result[gi] = r_result;
    end
  endgenerate

  assign rom_addr   = r_rom_addr;
  assign spi_start  = r_spi_start;
  assign spi_tx     = r_spi_tx;
  assign tdc_csn    = r_csn;
  assign cfg_done   = r_cfg_done;
  assign busy       = r_busy;
  assign meas_valid = r_meas_valid;
  assign timeout    = r_timeout;
  assign time1      = w_result[0];
  assign calib1     = w_result[1];
  assign calib2     = w_result[2];

endmodule

// File: tb/tb_tdc_seq_ctrl.sv
// Directed bench for tdc_seq_ctrl with a registered ROM model and a byte-level
// SPI model that answers 8 cycles after each spi_start.
module tb_tdc_seq_ctrl;

  localparam int TB_TO  = 200;
  localparam int TB_GAP = 4;

  localparam int SEL_CSN = 0;
  localparam int SEL_MV  = 1;
  localparam int SEL_CFG = 2;
  localparam int SEL_TO  = 3;
  localparam int SEL_CAL = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, spi_start, spi_done, tdc_csn, tdc_intb;
  logic        cfg_done, busy, meas_valid, timeout;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_data, spi_tx, spi_rx;
  logic [23:0] time1, calib1, calib2;

  logic [7:0] rom_mem [64];
  logic [7:0] rx_map  [64];

  typedef struct {
    logic [71:0] rx;
    logic [23:0] t1;
    logic [23:0] c1;
    logic [23:0] c2;
    bit          b2b;
    bit          poke;
  } vec_t;

  vec_t       vecs [3];
  logic [7:0] cfg_exp  [18];
  logic [7:0] meas_exp [14];

  int n_tests = 0;
  int n_fail  = 0;
  int inject_req = 0;

  tdc_seq_ctrl #(
    .INT_TIMEOUT (TB_TO),
    .CS_GAP      (TB_GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .spi_start  (spi_start),
    .spi_tx     (spi_tx),
    .spi_done   (spi_done),
    .spi_rx     (spi_rx),
    .tdc_csn    (tdc_csn),
    .tdc_intb   (tdc_intb),
    .cfg_done   (cfg_done),
    .busy       (busy),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .time1      (time1),
    .calib1     (calib1),
    .calib2     (calib2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // SPI master model
  int         spi_cnt = 0;
  int         inject_ack = 0;
  logic [5:0] lat_addr = '0;
  initial begin
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (!rst_n) begin
        spi_cnt = 0;
      end else begin
        if (inject_req != inject_ack) begin
          inject_ack = inject_req;
          spi_done   = 1'b1;
          spi_rx     = 8'h5A;
        end
        if (spi_cnt > 0) begin
          spi_cnt--;
          if (spi_cnt == 0) begin
            spi_done = 1'b1;
            spi_rx   = rx_map[lat_addr];
          end
        end
        if (spi_start) begin
          spi_cnt  = 8;
          lat_addr = rom_addr;
        end
      end
    end
  end

  // Bus monitor: logs bytes, chip-select windows and gaps
  logic [7:0] tx_log [$];
  int         win_log [$];
  int         gap_log [$];
  logic       csn_q = 1'b1;
  int         low_run = 0, high_run = 0, win_bytes = 0;
  int         csn_bad = 0, tx_unstable = 0, mv_count = 0;
  logic       in_xfer = 1'b0;
  logic [7:0] tx_held = '0;
  always @(negedge clk) begin
    if (tdc_csn && !csn_q) win_log.push_back(win_bytes);
    if (!tdc_csn && csn_q) begin
      gap_log.push_back(high_run);
      win_bytes = 0;
    end
    if (!rst_n) begin
      in_xfer = 1'b0;
    end else if (spi_start) begin
      tx_log.push_back(spi_tx);
      if (tdc_csn || low_run < 2) csn_bad++;
      win_bytes++;
      in_xfer = 1'b1;
      tx_held = spi_tx;
    end else if (in_xfer && spi_tx !== tx_held) begin
      tx_unstable++;
    end
    if (spi_done) in_xfer = 1'b0;
    if (meas_valid) mv_count++;
    if (tdc_csn) begin
      high_run++;
      low_run = 0;
    end else begin
      low_run++;
      high_run = 0;
    end
    csn_q = tdc_csn;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      SEL_CSN: return tdc_csn;
      SEL_MV:  return meas_valid;
      SEL_CFG: return cfg_done;
      SEL_TO:  return timeout;
      SEL_CAL: return (rom_addr >= 6'd25 && rom_addr <= 6'd27);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input int bound,
                          input string name, output int cycles);
    cycles = 0;
    while (get_sig(sel) !== val && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
    n_tests++;
    if (get_sig(sel) !== val) begin
      n_fail++;
      $display("FAIL %s: got %b after %0d cycles, expected %b", name, get_sig(sel), bound, val);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " rom_addr"},   32'(rom_addr),   32'h0);
    chk({tag, " spi_start"},  32'(spi_start),  32'h0);
    chk({tag, " spi_tx"},     32'(spi_tx),     32'h0);
    chk({tag, " tdc_csn"},    32'(tdc_csn),    32'h1);
    chk({tag, " cfg_done"},   32'(cfg_done),   32'h0);
    chk({tag, " busy"},       32'(busy),       32'h0);
    chk({tag, " meas_valid"}, 32'(meas_valid), 32'h0);
    chk({tag, " timeout"},    32'(timeout),    32'h0);
    chk({tag, " time1"},      32'(time1),      32'h0);
    chk({tag, " calib1"},     32'(calib1),     32'h0);
    chk({tag, " calib2"},     32'(calib2),     32'h0);
  endtask

  task automatic check_cfg(input int tx_b, input int win_b, input int gap_b);
    int bad;
    chk("cfg tx count", 32'(tx_log.size() - tx_b), 32'd18);
    for (int k = 0; k < 18; k++)
      if (tx_b + k < tx_log.size())
        chk($sformatf("cfg tx[%0d]", k), 32'(tx_log[tx_b + k]), 32'(cfg_exp[k]));
    chk("cfg csn windows", 32'(win_log.size() - win_b), 32'd9);
    bad = 0;
    for (int k = win_b; k < win_log.size(); k++) if (win_log[k] != 2) bad++;
    chk("cfg windows not 2 bytes", 32'(bad), 32'd0);
    bad = 0;
    for (int k = gap_b + 1; k < gap_log.size(); k++) if (gap_log[k] < TB_GAP) bad++;
    chk("cfg short csn gaps", 32'(bad), 32'd0);
    chk("cfg_done after cfg", 32'(cfg_done), 32'h1);
    chk("busy after cfg", 32'(busy), 32'h0);
    $display("[TB] config: %0d bytes in %0d windows", tx_log.size() - tx_b, win_log.size() - win_b);
  endtask

  task automatic run_meas(input int i);
    vec_t v;
    int   tx_b, mv0, cyc;
    v    = vecs[i];
    tx_b = tx_log.size();
    mv0  = mv_count;
    for (int k = 0; k < 3; k++) begin
      rx_map[21 + k] = v.rx[71 - 8 * k -: 8];
      rx_map[25 + k] = v.rx[47 - 8 * k -: 8];
      rx_map[29 + k] = v.rx[23 - 8 * k -: 8];
    end
    if (!v.b2b) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("meas%0d busy after start", i), 32'(busy), 32'h1);
    wait_for(SEL_CSN, 1'b0, 20, "trigger csn fall", cyc);
    wait_for(SEL_CSN, 1'b1, 100, "trigger csn rise", cyc);
    if (v.poke) begin
      repeat (50) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
    end else begin
      repeat (100) @(negedge clk);
    end
    tdc_intb = 1'b0;
    wait_for(SEL_MV, 1'b1, 400, "meas_valid", cyc);
    tdc_intb = 1'b1;
    chk($sformatf("meas%0d time1", i),  32'(time1),  32'(v.t1));
    chk($sformatf("meas%0d calib1", i), 32'(calib1), 32'(v.c1));
    chk($sformatf("meas%0d calib2", i), 32'(calib2), 32'(v.c2));
    chk($sformatf("meas%0d tx count", i), 32'(tx_log.size() - tx_b), 32'd14);
    for (int k = 0; k < 14; k++)
      if (tx_b + k < tx_log.size())
        chk($sformatf("meas%0d tx[%0d]", i, k), 32'(tx_log[tx_b + k]), 32'(meas_exp[k]));
    @(negedge clk);
    chk($sformatf("meas%0d meas_valid width", i), 32'(meas_valid), 32'h0);
    chk($sformatf("meas%0d busy idle", i), 32'(busy), 32'h0);
    chk($sformatf("meas%0d meas_valid pulses", i), 32'(mv_count - mv0), 32'd1);
    $display("[TB] meas %0d: time1=%06h calib1=%06h calib2=%06h", i, time1, calib1, calib2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx_b, win_b, gap_b, mv0, cyc;

    for (int k = 0; k < 64; k++) begin
      rom_mem[k] = 8'h00;
      rx_map[k]  = 8'hEE;
    end
    for (int k = 0; k < 9; k++) rom_mem[2 * k] = 8'h41 + 8'(k);
    rom_mem[1]  = 8'h40;
    rom_mem[18] = 8'h40;
    rom_mem[19] = 8'h81;
    rom_mem[20] = 8'h10;
    rom_mem[24] = 8'h1B;
    rom_mem[28] = 8'h1C;

    cfg_exp  = '{8'h41, 8'h40, 8'h42, 8'h00, 8'h43, 8'h00, 8'h44, 8'h00, 8'h45, 8'h00,
                 8'h46, 8'h00, 8'h47, 8'h00, 8'h48, 8'h00, 8'h49, 8'h00};
    meas_exp = '{8'h40, 8'h81, 8'h10, 8'h00, 8'h00, 8'h00, 8'h1B, 8'h00, 8'h00, 8'h00,
                 8'h1C, 8'h00, 8'h00, 8'h00};

    vecs[0] = '{rx: 72'h01_23_45_00_10_00_00_A0_00, t1: 24'h012345, c1: 24'h001000,
                c2: 24'h00A000, b2b: 1'b0, poke: 1'b0};
    vecs[1] = '{rx: 72'hFF_00_7E_12_34_56_AB_CD_EF, t1: 24'hFF007E, c1: 24'h123456,
                c2: 24'hABCDEF, b2b: 1'b1, poke: 1'b0};
    vecs[2] = '{rx: 72'h80_00_01_00_00_00_7F_FF_FF, t1: 24'h800001, c1: 24'h000000,
                c2: 24'h7FFFFF, b2b: 1'b0, poke: 1'b1};

    rst_n    = 1'b0;
    start    = 1'b0;
    tdc_intb = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");

    tx_b  = tx_log.size();
    win_b = win_log.size();
    gap_b = gap_log.size();
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(SEL_CFG, 1'b1, 3000, "cfg_done", cyc);
    check_cfg(tx_b, win_b, gap_b);

    // stray spi_done while idle
    tx_b = tx_log.size();
    inject_req++;
    repeat (20) @(negedge clk);
    chk("stray done tx count", 32'(tx_log.size() - tx_b), 32'd0);
    chk("stray done busy", 32'(busy), 32'h0);
    chk("stray done csn", 32'(tdc_csn), 32'h1);
    $display("[TB] stray spi_done in READY applied");

    for (int i = 0; i < 3; i++) begin
      run_meas(i);
      if (i + 1 < 3 && vecs[i + 1].b2b) start = 1'b1;
    end

    // interrupt timeout
    tx_b = tx_log.size();
    mv0  = mv_count;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(SEL_CSN, 1'b0, 20, "timeout trigger csn fall", cyc);
    wait_for(SEL_CSN, 1'b1, 100, "timeout trigger csn rise", cyc);
    wait_for(SEL_TO, 1'b1, 2 * TB_TO, "timeout pulse", cyc);
    chk("timeout latency from csn rise", 32'(cyc), 32'(TB_GAP + TB_TO));
    @(negedge clk);
    chk("timeout width", 32'(timeout), 32'h0);
    chk("timeout busy", 32'(busy), 32'h0);
    chk("timeout tx count", 32'(tx_log.size() - tx_b), 32'd2);
    chk("timeout time1 kept", 32'(time1), 32'h800001);
    chk("timeout calib1 kept", 32'(calib1), 32'h000000);
    chk("timeout calib2 kept", 32'(calib2), 32'h7FFFFF);
    chk("timeout no meas_valid", 32'(mv_count - mv0), 32'd0);
    $display("[TB] timeout after %0d cycles", cyc);

    // reset in the middle of the CALIB1 read
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(SEL_CSN, 1'b0, 20, "mid-reset trigger csn fall", cyc);
    wait_for(SEL_CSN, 1'b1, 100, "mid-reset trigger csn rise", cyc);
    repeat (100) @(negedge clk);
    tdc_intb = 1'b0;
    wait_for(SEL_CAL, 1'b1, 400, "reach CALIB1 read", cyc);
    rst_n = 1'b0;
    #1;
    check_reset("mid-reset");
    tdc_intb = 1'b1;
    repeat (3) @(negedge clk);
    tx_b  = tx_log.size();
    win_b = win_log.size();
    gap_b = gap_log.size();
    rst_n = 1'b1;
    wait_for(SEL_CFG, 1'b1, 3000, "cfg_done after mid-reset", cyc);
    check_cfg(tx_b, win_b, gap_b);
    run_meas(0);

    chk("csn low >=2 cycles before spi_start", 32'(csn_bad), 32'd0);
    chk("spi_tx stable during transfer", 32'(tx_unstable), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_seq_ctrl.md
# tdc_seq_ctrl

Sequencer between the TDC command ROM and the byte-level SPI master. After reset it walks the ROM to configure the TDC. On each `start` it writes the CONFIG1 trigger, waits for the TDC interrupt, then reads TIME1, CALIB1 and CALIB2 and presents them as 24-bit results.

## Interface
- `INT_TIMEOUT`, default 50000: cycles to wait for INTB after the trigger write before aborting.
- `CS_GAP`, default 4: minimum cycles `tdc_csn` stays high between transactions.
- `clk  in  1`: system clock. Single clock domain.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `start  in  1`: single-cycle request for a measurement. Sampled only in READY.
- `rom_addr  out  6`: command ROM index.
- `rom_data  in  8`: ROM byte, valid one cycle after `rom_addr` changes (registered ROM).
- `spi_start  out  1`: one-cycle pulse that launches one byte transfer.
- `spi_tx  out  8`: byte to send. Held stable from `spi_start` until `spi_done`.
- `spi_done  in  1`: one-cycle pulse marking the end of a byte transfer. `spi_rx` is valid with it.
- `spi_rx  in  8`: received byte.
- `tdc_csn  out  1`: TDC chip select, active-low.
- `tdc_intb  in  1`: TDC interrupt, active-low, asynchronous to `clk`.
- `cfg_done  out  1`: level; configuration is complete.
- `busy  out  1`: level; high in every state except READY.
- `meas_valid  out  1`: one-cycle pulse; result outputs are updated.
- `timeout  out  1`: one-cycle pulse; the measurement was aborted.
- `time1  out  24`, `calib1  out  24`, `calib2  out  24`: last good results.

## Operation
- Fixed ROM map:
  - 0..17: nine 2-byte configuration writes.
  - 18..19: CONFIG1 trigger write.
  - 20..23: TIME1 read (command byte + 3 data bytes).
  - 24..27: CALIB1 read (same layout).
  - 28..31: CALIB2 read (same layout).
- Transaction boundaries:
  - Below index 20, a transaction ends after an odd index.
  - From index 20, a transaction ends when `addr[1:0]==3`.
- States: CFG, FETCH, LOAD, XFER, GAP, READY, WAIT_INT, DONE.
  - FETCH: drive `rom_addr`.
  - LOAD: capture `rom_data` into `spi_tx`, pulse `spi_start`.
  - XFER: wait for `spi_done`.
  - At a transaction end go to GAP; otherwise increment the address and return to FETCH.
- Sequence:
  - Reset → CFG → walk 0..17 → GAP → READY, `cfg_done`=1.
  - READY with `start` → walk 18..19 → GAP → WAIT_INT.
  - WAIT_INT on synchronized `tdc_intb`=0 → walk 20..31 → GAP → DONE → READY.
- Read capture: data bytes arrive MSB first. The 1st/2nd/3rd `spi_rx` of a read go to bits [23:16]/[15:8]/[7:0]. The `spi_rx` from the command byte is discarded.
- Shadow registers: reads accumulate in shadow registers. `time1`/`calib1`/`calib2` update together in DONE, and `meas_valid` pulses in the same cycle.
- Timeout: a counter starts on entry to WAIT_INT. On reaching `INT_TIMEOUT` with no interrupt, pulse `timeout`, go to READY, and leave the results unchanged.
- Ignored inputs:
  - `start` outside READY, including during CFG.
  - `spi_done` outside XFER.
- `tdc_intb` passes through a 2-flop synchronizer before use.

## Timing
- Reset values: `rom_addr`=0, `spi_start`=0, `spi_tx`=0, `tdc_csn`=1, `cfg_done`=0, `busy`=0, `meas_valid`=0, `timeout`=0, results=0. CFG begins on the first clock edge after `rst_n` deasserts.
- Chip select:
  - `tdc_csn` falls on entry to the FETCH of a transaction's first byte, i.e. at least 2 cycles before `spi_start`.
  - It rises in the cycle after the last byte's `spi_done`.
  - It then stays high for `CS_GAP` cycles, which GAP counts.
- Byte pacing: `spi_start` comes 2 cycles after the address is driven. Bytes within one transaction are separated by `spi_done` → FETCH → LOAD, so `tdc_csn` stays low across the whole transaction.
- READY → `busy` high in the cycle after `start` is sampled.
- `meas_valid` fires `CS_GAP`+1 cycles after the final `spi_done`.
- Interrupt latency: WAIT_INT exits 2–3 cycles after `tdc_intb` falls (synchronizer delay).
- Mid-operation reset: `rst_n` low at any point immediately forces `tdc_csn`=1 and all outputs to their reset values. Configuration then replays in full.

## Structure
- Shared package/include `tdc_seq_pkg`:
  - State encoding.
  - ROM index constants: `CFG_LAST`=17, `TRIG_ADDR`=18, `TIME1_ADDR`=20, `CALIB1_ADDR`=24, `CALIB2_ADDR`=28, `LAST_ADDR`=31.
  - Result width 24.
- One sub-module, `sync2`: 2-flop synchronizer for `tdc_intb`, with reset value 1.
- The ROM and the SPI master are external.

## Test plan
- Release reset with an SPI model that returns `spi_done` 8 cycles after `spi_start` → nine `tdc_csn`-low windows of 2 bytes each, `spi_tx` sequence 41,40,42,00,…,49,00, ≥`CS_GAP` high cycles between windows, then `cfg_done`=1 and `busy`=0.
- `start`; `tdc_intb` falls 100 cycles after the trigger; model returns 01 23 45 / 00 10 00 / 00 A0 00 for the data bytes → `tx`=40,81 then 10,00,00,00 / 1B,… / 1C,…; `time1`=0x012345, `calib1`=0x001000, `calib2`=0x00A000; one-cycle `meas_valid`.
- `INT_TIMEOUT`=200, `tdc_intb` held high → `timeout` pulse 200 cycles after entering WAIT_INT; no read transfers; results unchanged; `busy`=0 afterwards.
- `start` during CFG and during WAIT_INT; a stray `spi_done` in READY → no extra transfers, no state change.
- Assert `rst_n` in the middle of the CALIB1 read → `tdc_csn`=1 immediately, all outputs at reset values, and the configuration sequence reruns from 41,40.
- Two back-to-back `start` pulses, the second one cycle after `meas_valid` → the second measurement runs cleanly with correct new results.
